// File: rtl/memwrite_trace_fifo_if.sv
// Store-capture port bundle: processor store strobe/data in, valid/ready drain port and status out.
// master = processor/consumer side, slave = the trace FIFO.
interface memwrite_trace_fifo_if #(
  parameter int WIDTH = 32,
  parameter int AW    = 4
);
  logic             memwrite;
  logic [WIDTH-1:0] writedata;
  logic             filter_zero;
  logic             clear;
  logic             out_valid;
  logic [WIDTH-1:0] out_data;
  logic             out_ready;
  logic [AW:0]      count;
  logic             overflow;
  logic [7:0]       drop_count;

  modport master (
    output memwrite, writedata, filter_zero, clear, out_ready,
    input  out_valid, out_data, count, overflow, drop_count
  );

  modport slave (
    input  memwrite, writedata, filter_zero, clear, out_ready,
    output out_valid, out_data, count, overflow, drop_count
  );
endinterface

// File: rtl/memwrite_trace_fifo.sv
// Captures every processor store into a small show-ahead FIFO drained via valid/ready,
// with a sticky overflow flag and a saturating count of stores lost to a full queue.
module memwrite_trace_fifo #(
  parameter int WIDTH = 32,
  parameter int DEPTH = 16,
  parameter int AW    = 4
) (
  input  logic                 clk,
  input  logic                 reset,
  memwrite_trace_fifo_if.slave bus
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr_reg;
  logic [AW-1:0]    rd_ptr_reg;
  logic [AW:0]      count_reg;
  logic             overflow_reg;
  logic [7:0]       drop_count_reg;

  logic cap;
  logic full;
  logic pop;
  logic push;
  logic drop;

  assign cap  = bus.memwrite & ~(bus.filter_zero & (bus.writedata == '0));
  assign full = (count_reg == (AW+1)'(DEPTH));
  assign pop  = (count_reg != '0) & bus.out_ready;
  // A pop in the same cycle frees the slot, so a full queue still accepts the store.
  assign push = cap & (~full | pop);
  assign drop = cap & full & ~pop;

  // Storage is not reset; entries are only visible once count covers them.
  always_ff @(posedge clk) begin
    if (push && !bus.clear) begin
      mem[wr_ptr_reg] <= bus.writedata;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else if (bus.clear) begin
      wr_ptr_reg     <= '0;
      rd_ptr_reg     <= '0;
      count_reg      <= '0;
      overflow_reg   <= 1'b0;
      drop_count_reg <= 8'd0;
    end else begin
      if (push) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg <= rd_ptr_reg + 1'b1;
      end
      count_reg <= count_reg + (AW+1)'(push) - (AW+1)'(pop);
      if (drop) begin
        overflow_reg <= 1'b1;
        if (drop_count_reg != 8'hFF) begin
          drop_count_reg <= drop_count_reg + 8'd1;
        end
      end
    end
  end

  assign bus.out_valid  = (count_reg != '0);
  assign bus.out_data   = mem[rd_ptr_reg];
  assign bus.count      = count_reg;
  assign bus.overflow   = overflow_reg;
  assign bus.drop_count = drop_count_reg;

endmodule

// File: tb/tb_memwrite_trace_fifo.sv
// Bench for memwrite_trace_fifo: queue-based reference model checked every cycle,
// plus directed scenarios with literal expectations.
module tb_memwrite_trace_fifo;
  localparam int WIDTH = 32;
  localparam int DEPTH = 16;
  localparam int AW    = 4;

  logic clk;
  logic reset;
  int   n_cmp;
  int   n_fail;

  memwrite_trace_fifo_if #(.WIDTH(WIDTH), .AW(AW)) bus ();

  memwrite_trace_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AW(AW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference model: plain queue of stored values.
  logic [31:0] mq[$];
  logic [31:0] popped[$];
  bit          m_ovf;
  int          m_drops;
  bit          m_pop;
  bit          m_cap;

  always @(posedge clk or posedge reset) begin
    if (reset || bus.clear) begin
      mq.delete();
      m_ovf   = 1'b0;
      m_drops = 0;
    end else begin
      m_pop = (mq.size() != 0) && bus.out_ready;
      m_cap = bus.memwrite && !(bus.filter_zero && bus.writedata == 0);
      if (m_pop) popped.push_back(mq.pop_front());
      if (m_cap) begin
        if (mq.size() < DEPTH) mq.push_back(bus.writedata);
        else begin
          m_ovf = 1'b1;
          if (m_drops < 255) m_drops++;
        end
      end
    end
  end

  task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chk_seq(string name, logic [31:0] exp[$]);
    chk({name, "_len"}, 32'(popped.size()), 32'(exp.size()));
    for (int i = 0; i < exp.size() && i < popped.size(); i++)
      chk(name, popped[i], exp[i]);
  endtask

  // Per-cycle compare against the model, away from the active edge.
  always @(negedge clk) begin
    chk("count", 32'(bus.count), 32'(mq.size()));
    chk("out_valid", 32'(bus.out_valid), (mq.size() != 0) ? 32'd1 : 32'd0);
    chk("overflow", 32'(bus.overflow), 32'(m_ovf));
    chk("drop_count", 32'(bus.drop_count), 32'(m_drops));
    if (mq.size() != 0) chk("out_data", bus.out_data, mq[0]);
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drive(bit mw, logic [31:0] wd, bit rdy);
    bus.memwrite  = mw;
    bus.writedata = wd;
    bus.out_ready = rdy;
    step();
  endtask

  initial begin
    logic [31:0] exp[$];
    n_cmp  = 0;
    n_fail = 0;
    reset  = 1'b0;
    bus.memwrite    = 1'b0;
    bus.writedata   = '0;
    bus.filter_zero = 1'b0;
    bus.clear       = 1'b0;
    bus.out_ready   = 1'b0;
    #1 reset = 1'b1;

    // 1) reset
    step(); step();
    reset = 1'b0;
    step();
    chk("t1_count", 32'(bus.count), 0);
    chk("t1_valid", 32'(bus.out_valid), 0);
    chk("t1_ovf", 32'(bus.overflow), 0);
    chk("t1_drops", 32'(bus.drop_count), 0);

    // 2) two stores, then drain
    popped.delete();
    drive(1, 24, 0);
    chk("t2_count1", 32'(bus.count), 1);
    chk("t2_head24", bus.out_data, 24);
    drive(1, 6, 0);
    chk("t2_count2", 32'(bus.count), 2);
    chk("t2_head24b", bus.out_data, 24);
    drive(0, 0, 1);
    chk("t2_head6", bus.out_data, 6);
    drive(0, 0, 1);
    chk("t2_empty", 32'(bus.out_valid), 0);
    exp = '{24, 6};
    chk_seq("t2_order", exp);

    // 3) zero filter
    bus.filter_zero = 1'b1;
    drive(1, 0, 0); drive(1, 5, 0); drive(1, 0, 0); drive(0, 0, 0);
    chk("t3_filt_count", 32'(bus.count), 1);
    chk("t3_filt_head", bus.out_data, 5);
    chk("t3_filt_drops", 32'(bus.drop_count), 0);
    drive(0, 0, 1);
    bus.filter_zero = 1'b0;
    drive(1, 0, 0); drive(1, 5, 0); drive(1, 0, 0); drive(0, 0, 0);
    chk("t3_nofilt_count", 32'(bus.count), 3);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);

    // 4) fill, overflow, simultaneous push/pop at full
    popped.delete();
    for (int i = 1; i <= 16; i++) drive(1, 32'(i), 0);
    chk("t4_full", 32'(bus.count), 16);
    chk("t4_no_ovf", 32'(bus.overflow), 0);
    drive(1, 17, 0);
    chk("t4_ovf", 32'(bus.overflow), 1);
    chk("t4_drop1", 32'(bus.drop_count), 1);
    chk("t4_full17", 32'(bus.count), 16);
    drive(1, 18, 1);
    chk("t4_full18", 32'(bus.count), 16);
    chk("t4_drop_still1", 32'(bus.drop_count), 1);
    chk("t4_head2", bus.out_data, 2);
    for (int i = 0; i < 16; i++) drive(0, 0, 1);
    chk("t4_drained", 32'(bus.count), 0);
    exp.delete();
    for (int i = 1; i <= 16; i++) exp.push_back(32'(i));
    exp.push_back(18);
    chk_seq("t4_order", exp);

    // 5) push/pop pairs across pointer wrap, drop saturation, clear
    popped.delete();
    for (int i = 0; i < 8; i++) drive(1, 32'(100 + i), 0);
    for (int i = 0; i < 20; i++) drive(1, 32'(200 + i), 1);
    chk("t5_half", 32'(bus.count), 8);
    for (int i = 0; i < 8; i++) drive(0, 0, 1);
    exp.delete();
    for (int i = 0; i < 8; i++) exp.push_back(32'(100 + i));
    for (int i = 0; i < 20; i++) exp.push_back(32'(200 + i));
    chk_seq("t5_order", exp);
    for (int i = 0; i < 16; i++) drive(1, 32'(500 + i), 0);
    for (int i = 0; i < 300; i++) drive(1, 7, 0);
    chk("t5_sat", 32'(bus.drop_count), 255);
    chk("t5_sat_head", bus.out_data, 500);
    bus.clear = 1'b1;
    drive(1, 9, 1);
    bus.clear = 1'b0;
    chk("t5_clr_count", 32'(bus.count), 0);
    chk("t5_clr_valid", 32'(bus.out_valid), 0);
    chk("t5_clr_ovf", 32'(bus.overflow), 0);
    chk("t5_clr_drops", 32'(bus.drop_count), 0);

    // 6) async reset mid-drain
    for (int i = 1; i <= 10; i++) drive(1, 32'(i), 0);
    for (int i = 0; i < 3; i++) drive(0, 0, 1);
    chk("t6_count7", 32'(bus.count), 7);
    chk("t6_head4", bus.out_data, 4);
    #2 reset = 1'b1;
    #1;
    chk("t6_async_count", 32'(bus.count), 0);
    chk("t6_async_valid", 32'(bus.out_valid), 0);
    step(); step();
    reset = 1'b0;
    drive(1, 42, 0);
    drive(0, 0, 0);
    chk("t6_after_count", 32'(bus.count), 1);
    chk("t6_after_head", bus.out_data, 42);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end
endmodule
